// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage
// ---------------------
// Register-file and ALU-operand stage between the control FSM / memory
// interface and the ALU. Holds the instruction register (IR), the memory
// data register (MDR), a NUM_REGS-deep register file, the write-data and
// write-address muxes, and the registered ALU operands A/B with a
// request/valid handshake.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   IR_IN, IRwrtCTRL    instruction word and its load enable
//   MemO_IN, memOWCTRL  memory read data and MDR load enable
//   ALUOut, SEIMM,
//   LINK_IN             candidate register write data
//   wDatCTRL            write-data select (ALUOut / MDR / SEIMM / LINK_IN)
//   wAdrsCTRL           write-address select (field A / field B)
//   RegWrtCTRL          register-file write enable
//   useFirstRegCTRL     operand A from R0 instead of reg[field A]
//   useRegCTRL          operand B from SEIMM instead of reg[field B]
//   op_req / op_valid   latch operands / one-cycle pulse after the latch
//   AiAOUT, AiBOUT      latched operands
//   REG0OUT             live R0 contents
//   IR_OUT, MDR_OUT     IR and MDR contents
module regfile_operand_stage #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int REG0_ZERO = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IR_IN,
    input  logic              IRwrtCTRL,
    input  logic [DATA_W-1:0] MemO_IN,
    input  logic              memOWCTRL,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] SEIMM,
    input  logic [DATA_W-1:0] LINK_IN,
    input  logic [1:0]        wDatCTRL,
    input  logic              wAdrsCTRL,
    input  logic              RegWrtCTRL,
    input  logic              useFirstRegCTRL,
    input  logic              useRegCTRL,
    input  logic              op_req,
    output logic              op_valid,
    output logic [DATA_W-1:0] AiAOUT,
    output logic [DATA_W-1:0] AiBOUT,
    output logic [DATA_W-1:0] REG0OUT,
    output logic [DATA_W-1:0] IR_OUT,
    output logic [DATA_W-1:0] MDR_OUT
);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [ADDR_W-1:0] field_a, field_b, waddr, opa_idx;
    logic [DATA_W-1:0] wdata, rd_a, rd_b;
    logic              wr_en;

    // Register read with same-cycle write bypass; index 0 is forced to zero
    // when R0 is hardwired so neither the array nor the bypass can leak data.
    function automatic logic [DATA_W-1:0] rd_bypass(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] val;
        val = (we && (wa == idx)) ? wd : stored;
        if ((REG0_ZERO != 0) && (idx == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    // Fields always come from the latched IR, so a same-cycle IR load
    // does not affect this cycle's write address or reads.
    assign field_a = ir_q[DATA_W-5 -: ADDR_W];
    assign field_b = ir_q[DATA_W-5-ADDR_W -: ADDR_W];

    always_comb begin
        waddr = wAdrsCTRL ? field_b : field_a;
        unique case (wDatCTRL)
            2'd0:    wdata = ALUOut;
            2'd1:    wdata = mdr_q;
            2'd2:    wdata = SEIMM;
            default: wdata = LINK_IN;
        endcase
        // Writes to a hardwired R0 are dropped here, which also keeps the
        // bypass path from forwarding them.
        wr_en = RegWrtCTRL && !((REG0_ZERO != 0) && (waddr == '0));
    end

    always_comb begin
        opa_idx = useFirstRegCTRL ? '0 : field_a;
        rd_a    = rd_bypass(opa_idx, regs_q[opa_idx], wr_en, waddr, wdata);
        rd_b    = rd_bypass(field_b, regs_q[field_b], wr_en, waddr, wdata);

        ir_d  = IRwrtCTRL ? IR_IN : ir_q;
        mdr_d = memOWCTRL ? MemO_IN : mdr_q;
        opa_d = opa_q;
        opb_d = opb_q;
        vld_d = 1'b0;
        if (op_req) begin
            opa_d = rd_a;
            opb_d = useRegCTRL ? SEIMM : rd_b;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ir_q  <= '0;
            mdr_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ir_q  <= ir_d;
            mdr_q <= mdr_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            vld_q <= vld_d;
            if (wr_en) begin
                regs_q[waddr] <= wdata;
            end
        end
    end

    assign op_valid = vld_q;
    assign AiAOUT   = opa_q;
    assign AiBOUT   = opb_q;
    assign IR_OUT   = ir_q;
    assign MDR_OUT  = mdr_q;
    assign REG0OUT  = (REG0_ZERO != 0) ? '0 : regs_q[0];

endmodule

// File: tb/tb_regfile_operand_stage.sv
module tb_regfile_operand_stage;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] IR_IN, MemO_IN, ALUOut, SEIMM, LINK_IN;
    logic         IRwrtCTRL, memOWCTRL, wAdrsCTRL, RegWrtCTRL;
    logic [1:0]   wDatCTRL;
    logic         useFirstRegCTRL, useRegCTRL, op_req;

    logic         op_valid, op_valid_z;
    logic [W-1:0] AiAOUT, AiBOUT, REG0OUT, IR_OUT, MDR_OUT;
    logic [W-1:0] AiAOUT_z, AiBOUT_z, REG0OUT_z, IR_OUT_z, MDR_OUT_z;

    int checks = 0;
    int failures = 0;

    // Expected operand pairs {A, B} for each instance.
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_qz[$];

    always #5 CLK = ~CLK;

    regfile_operand_stage #(.DATA_W(W), .NUM_REGS(16), .REG0_ZERO(0)) dut (
        .CLK(CLK), .RESET(RESET), .IR_IN(IR_IN), .IRwrtCTRL(IRwrtCTRL),
        .MemO_IN(MemO_IN), .memOWCTRL(memOWCTRL), .ALUOut(ALUOut),
        .SEIMM(SEIMM), .LINK_IN(LINK_IN), .wDatCTRL(wDatCTRL),
        .wAdrsCTRL(wAdrsCTRL), .RegWrtCTRL(RegWrtCTRL),
        .useFirstRegCTRL(useFirstRegCTRL), .useRegCTRL(useRegCTRL),
        .op_req(op_req), .op_valid(op_valid), .AiAOUT(AiAOUT),
        .AiBOUT(AiBOUT), .REG0OUT(REG0OUT), .IR_OUT(IR_OUT), .MDR_OUT(MDR_OUT)
    );

    regfile_operand_stage #(.DATA_W(W), .NUM_REGS(16), .REG0_ZERO(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .IR_IN(IR_IN), .IRwrtCTRL(IRwrtCTRL),
        .MemO_IN(MemO_IN), .memOWCTRL(memOWCTRL), .ALUOut(ALUOut),
        .SEIMM(SEIMM), .LINK_IN(LINK_IN), .wDatCTRL(wDatCTRL),
        .wAdrsCTRL(wAdrsCTRL), .RegWrtCTRL(RegWrtCTRL),
        .useFirstRegCTRL(useFirstRegCTRL), .useRegCTRL(useRegCTRL),
        .op_req(op_req), .op_valid(op_valid_z), .AiAOUT(AiAOUT_z),
        .AiBOUT(AiBOUT_z), .REG0OUT(REG0OUT_z), .IR_OUT(IR_OUT_z), .MDR_OUT(MDR_OUT_z)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET = 0; IRwrtCTRL = 0; memOWCTRL = 0; RegWrtCTRL = 0;
        wAdrsCTRL = 0; wDatCTRL = 2'd0; useFirstRegCTRL = 0; useRegCTRL = 0;
        op_req = 0;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] az, input logic [W-1:0] bz);
        exp_q.push_back({a, b});
        exp_qz.push_back({az, bz});
    endtask

    // Monitors: every op_valid pulse consumes one expected operand pair.
    always @(negedge CLK) begin
        logic [2*W-1:0] e;
        if (op_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL op_valid_unexpected: got 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                chk("opA", AiAOUT, e[2*W-1:W]);
                chk("opB", AiBOUT, e[W-1:0]);
            end
        end
    end

    always @(negedge CLK) begin
        logic [2*W-1:0] e;
        if (op_valid_z === 1'b1) begin
            if (exp_qz.size() == 0) begin
                checks++; failures++;
                $display("FAIL op_valid_z_unexpected: got 1 expected 0");
            end else begin
                e = exp_qz.pop_front();
                chk("z_opA", AiAOUT_z, e[2*W-1:W]);
                chk("z_opB", AiBOUT_z, e[W-1:0]);
            end
        end
    end

    initial begin
        logic [W-1:0] hold_a, hold_b;
        idle();
        IR_IN = '0; MemO_IN = '0; ALUOut = '0; SEIMM = '0; LINK_IN = '0;

        // Reset with every input active and nonzero.
        RESET = 1; IR_IN = 16'hFFFF; IRwrtCTRL = 1; MemO_IN = 16'hFFFF; memOWCTRL = 1;
        ALUOut = 16'h5A5A; SEIMM = 16'h1111; LINK_IN = 16'h2222; wDatCTRL = 2'd3;
        wAdrsCTRL = 1; RegWrtCTRL = 1; useFirstRegCTRL = 1; useRegCTRL = 1; op_req = 1;
        tick();
        idle();
        chk("rst_IR", IR_OUT, 16'h0);
        chk("rst_MDR", MDR_OUT, 16'h0);
        chk("rst_A", AiAOUT, 16'h0);
        chk("rst_B", AiBOUT, 16'h0);
        chk("rst_R0", REG0OUT, 16'h0);
        chk("rst_vld", {15'b0, op_valid}, 16'h0);

        // Every register reads 0 after reset.
        for (int k = 0; k < 8; k++) begin
            IR_IN = {4'h0, 4'(2 * k), 4'(2 * k + 1), 4'h0};
            IRwrtCTRL = 1;
            tick();
            IRwrtCTRL = 0;
            op_req = 1;
            push(16'h0, 16'h0, 16'h0, 16'h0);
            tick();
            op_req = 0;
        end
        tick();

        // Load IR and MDR, write MDR into reg[field A]=R1, then read.
        IR_IN = 16'h0120; IRwrtCTRL = 1; MemO_IN = 16'd123; memOWCTRL = 1;
        tick();
        idle();
        chk("ld_IR", IR_OUT, 16'h0120);
        chk("ld_MDR", MDR_OUT, 16'd123);
        wDatCTRL = 2'd1; wAdrsCTRL = 0; RegWrtCTRL = 1;
        tick();
        idle();
        op_req = 1;
        push(16'd123, 16'h0, 16'd123, 16'h0);
        tick();
        idle();
        chk("vld_hi", {15'b0, op_valid}, 16'h1);
        tick();
        chk("vld_pulse", {15'b0, op_valid}, 16'h0);

        // Bypass: write ALUOut to R2 (field B) and read it in the same cycle.
        ALUOut = 16'h00AA; wDatCTRL = 2'd0; wAdrsCTRL = 1; RegWrtCTRL = 1; op_req = 1;
        push(16'd123, 16'h00AA, 16'd123, 16'h00AA);
        tick();
        idle();
        op_req = 1;
        push(16'd123, 16'h00AA, 16'd123, 16'h00AA);
        tick();
        idle();
        tick();

        // Operand sources: R0 via field B, then R0 / SEIMM operands.
        IR_IN = 16'h0100; IRwrtCTRL = 1;
        tick();
        idle();
        ALUOut = 16'h0055; wDatCTRL = 2'd0; wAdrsCTRL = 1; RegWrtCTRL = 1;
        tick();
        idle();
        chk("R0_write", REG0OUT, 16'h0055);
        chk("z_R0_write", REG0OUT_z, 16'h0000);
        useFirstRegCTRL = 1; useRegCTRL = 1; SEIMM = 16'hFFF6; op_req = 1;
        push(16'h0055, 16'hFFF6, 16'h0000, 16'hFFF6);
        tick();
        idle();
        chk("A_eq_R0", AiAOUT, REG0OUT);
        hold_a = 16'h0055; hold_b = 16'hFFF6;
        SEIMM = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_A", AiAOUT, hold_a);
            chk("hold_B", AiBOUT, hold_b);
            chk("hold_vld", {15'b0, op_valid}, 16'h0);
        end

        // R0 write with same-cycle bypass read (IR=0x0100: A=R1, B=R0).
        ALUOut = 16'h1234; wDatCTRL = 2'd0; wAdrsCTRL = 1; RegWrtCTRL = 1;
        useFirstRegCTRL = 1; op_req = 1;
        push(16'h1234, 16'h1234, 16'h0000, 16'h0000);
        tick();
        idle();
        chk("R0_1234", REG0OUT, 16'h1234);
        chk("z_R0_zero", REG0OUT_z, 16'h0000);

        // LINK_IN into R1, then read R1 / R0.
        LINK_IN = 16'hBEEF; wDatCTRL = 2'd3; wAdrsCTRL = 0; RegWrtCTRL = 1;
        tick();
        idle();
        op_req = 1;
        push(16'hBEEF, 16'h1234, 16'hBEEF, 16'h0000);
        tick();
        idle();

        // SEIMM into R1 (bypass on operand A).
        SEIMM = 16'h7FFF; wDatCTRL = 2'd2; wAdrsCTRL = 0; RegWrtCTRL = 1; op_req = 1;
        push(16'h7FFF, 16'h1234, 16'h7FFF, 16'h0000);
        tick();
        idle();

        // MDR source uses the old MDR while a new value loads.
        MemO_IN = 16'h9999; memOWCTRL = 1; wDatCTRL = 2'd1; wAdrsCTRL = 0; RegWrtCTRL = 1;
        tick();
        idle();
        chk("MDR_new", MDR_OUT, 16'h9999);
        op_req = 1;
        push(16'd123, 16'h1234, 16'd123, 16'h0000);
        tick();
        idle();

        // IR load and register write together: address from the old IR (A=R1).
        IR_IN = 16'h0F30; IRwrtCTRL = 1; ALUOut = 16'h0ABC; wDatCTRL = 2'd0;
        wAdrsCTRL = 0; RegWrtCTRL = 1;
        tick();
        idle();
        chk("IR_new", IR_OUT, 16'h0F30);
        IR_IN = 16'h0100; IRwrtCTRL = 1;
        tick();
        idle();
        op_req = 1;
        push(16'h0ABC, 16'h1234, 16'h0ABC, 16'h0000);
        tick();
        idle();

        // Reset wins over write, op_req and IR load in the same cycle.
        RESET = 1; ALUOut = 16'h4444; wDatCTRL = 2'd0; wAdrsCTRL = 0; RegWrtCTRL = 1;
        op_req = 1; IR_IN = 16'h0F00; IRwrtCTRL = 1;
        tick();
        idle();
        chk("mid_IR", IR_OUT, 16'h0);
        chk("mid_A", AiAOUT, 16'h0);
        chk("mid_B", AiBOUT, 16'h0);
        chk("mid_vld", {15'b0, op_valid}, 16'h0);
        chk("mid_R0", REG0OUT, 16'h0);

        // Resume: IR=0x0230 (A=R2, B=R3), write R2 with bypass read.
        IR_IN = 16'h0230; IRwrtCTRL = 1;
        tick();
        idle();
        chk("res_IR", IR_OUT, 16'h0230);
        ALUOut = 16'h0777; wDatCTRL = 2'd0; wAdrsCTRL = 0; RegWrtCTRL = 1; op_req = 1;
        push(16'h0777, 16'h0000, 16'h0777, 16'h0000);
        tick();
        idle();
        op_req = 1;
        push(16'h0777, 16'h0000, 16'h0777, 16'h0000);
        tick();
        idle();
        tick();
        tick();

        chk("sb_empty", 16'(exp_q.size()), 16'h0);
        chk("z_sb_empty", 16'(exp_qz.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
